// File: rtl/period_meter.sv
// period_meter: measures the interval between successive rising edges of an
// asynchronous input. The interval is counted in tick_en units. Each result
// is handed to the consumer through a valid/ack handshake. The block flags
// a stalled input (timeout) and results that were overwritten before ack.
module period_meter #(
   parameter int CNT_WIDTH   = 16,
   parameter int TIMEOUT     = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk_in,
   input  logic                 reset_in,
   input  logic                 tick_en,
   input  logic                 sig_in,
   input  logic                 period_ack,
   output logic [CNT_WIDTH-1:0] period_out,
   output logic                 period_valid,
   output logic                 overrun,
   output logic                 stalled
);

   localparam logic STATE_IDLE    = 1'b0;
   localparam logic STATE_MEASURE = 1'b1;

   // Last count value before a measurement is abandoned
   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(TIMEOUT - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_state;
   logic [CNT_WIDTH-1:0]   r_count;
   logic [CNT_WIDTH-1:0]   r_periodOut;
   logic                   r_periodValid;
   logic                   r_overrun;
   logic                   r_stalled;

   logic                   w_edge;
   logic                   w_capture;

   // Rising edge of the synchronized input, one cycle wide per transition
   assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_prev;
   // An edge while measuring closes the current interval and yields a result
   assign w_capture = (r_state == STATE_MEASURE) & w_edge;

   // Bring sig_in into the clk_in domain and keep one cycle of history
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // Arm on the first edge, count ticks while measuring, give up on timeout
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_state   <= STATE_IDLE;
         r_count   <= '0;
         r_stalled <= 1'b1;
      end else begin
         case (r_state)
            STATE_IDLE: begin
               r_count <= '0;
               if (w_edge) begin
                  r_state   <= STATE_MEASURE;
                  r_stalled <= 1'b0;
               end
            end
            STATE_MEASURE: begin
               if (w_edge) begin
                  r_count <= '0;
               end else if (tick_en) begin
                  if (r_count == LAST_COUNT) begin
                     r_count   <= '0;
                     r_state   <= STATE_IDLE;
                     r_stalled <= 1'b1;
                  end else begin
                     r_count <= r_count + CNT_WIDTH'(1);
                  end
               end
            end
            default: begin
               r_state <= STATE_IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

   // Publish results and track the consumer handshake and overwrites
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_periodOut   <= '0;
         r_periodValid <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         if (w_capture) begin
            r_periodOut   <= r_count;
            r_periodValid <= 1'b1;
            r_overrun     <= r_periodValid & ~period_ack;
         end else begin
            r_overrun <= 1'b0;
            if (period_ack) begin
               r_periodValid <= 1'b0;
            end
         end
      end
   end

   assign period_out   = r_periodOut;
   assign period_valid = r_periodValid;
   assign overrun      = r_overrun;
   assign stalled      = r_stalled;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: randomized and directed stimulus for period_meter. An
// event-level reference model predicts results into a queue. A negedge
// monitor pops and compares each result the DUT presents.
module tb_period_meter;

   localparam int CW = 16;
   localparam int TO = 100;
   localparam int SS = 2;

   logic          clk_in = 1'b0;
   logic          reset_in;
   logic          tick_en;
   logic          sig_in;
   logic          period_ack;
   logic [CW-1:0] period_out;
   logic          period_valid;
   logic          overrun;
   logic          stalled;

   typedef struct {
      int period;
      bit ov;
   } result_t;

   result_t expQ[$];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // Reference model state: sampled input history, ticks since arming
   bit hist[0:SS];
   bit armed;
   int ticksSince;
   bit stalledM;
   bit validM;
   bit ovM;

   // Monitor bookkeeping
   bit prevValid;
   bit prevAck;
   int resultCount = 0;
   int ovCount     = 0;
   int lastPeriod  = 0;
   bit randomAck   = 1'b0;

   period_meter #(
      .CNT_WIDTH  (CW),
      .TIMEOUT    (TO),
      .SYNC_STAGES(SS)
   ) dut (
      .clk_in      (clk_in),
      .reset_in    (reset_in),
      .tick_en     (tick_en),
      .sig_in      (sig_in),
      .period_ack  (period_ack),
      .period_out  (period_out),
      .period_valid(period_valid),
      .overrun     (overrun),
      .stalled     (stalled)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #2;
      end
   endtask

   task automatic alignPhase(input int p);
      do waitCycles(1); while ((cyc % 4) != p);
   endtask

   task automatic applyStimulus(input int n, input int highCycles, input int lowCycles);
      repeat (n) begin
         sig_in = 1'b1;
         waitCycles(highCycles);
         sig_in = 1'b0;
         waitCycles(lowCycles);
      end
   endtask

   task automatic goIdle();
      sig_in = 1'b0;
      waitCycles(420);
   endtask

   // Tick every 4th cycle; optionally randomize the ack line
   initial begin
      tick_en = 1'b0;
      forever begin
         @(posedge clk_in);
         cyc++;
         #2;
         tick_en = ((cyc % 4) == 0);
         if (randomAck) period_ack = 1'($urandom_range(0, 1));
      end
   end

   // Reference model: an input rise is recognized SS cycles after sampling.
   // A result is the number of ticks strictly between two recognized edges,
   // and a measurement is dropped once TO ticks have elapsed.
   always @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
         armed      = 1'b0;
         ticksSince = 0;
         stalledM   = 1'b1;
         validM     = 1'b0;
         ovM        = 1'b0;
         expQ.delete();
      end else begin
         bit edgeSeen;
         bit produced;
         edgeSeen = hist[SS-1] && !hist[SS];
         produced = 1'b0;
         ovM      = 1'b0;
         if (edgeSeen) begin
            if (armed) begin
               result_t r;
               r.period = ticksSince;
               r.ov     = validM && !period_ack;
               ovM      = r.ov;
               expQ.push_back(r);
               produced = 1'b1;
            end
            armed      = 1'b1;
            ticksSince = 0;
            stalledM   = 1'b0;
         end else if (armed && tick_en) begin
            ticksSince++;
            if (ticksSince == TO) begin
               armed      = 1'b0;
               ticksSince = 0;
               stalledM   = 1'b1;
            end
         end
         if (produced) validM = 1'b1;
         else if (period_ack) validM = 1'b0;
         for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = sig_in;
      end
   end

   // Monitor: per-cycle status checks, and a scoreboard pop whenever the
   // DUT presents a fresh result
   always @(negedge clk_in) begin
      checkOutput("stalled", int'(stalled), int'(stalledM));
      checkOutput("period_valid", int'(period_valid), int'(validM));
      checkOutput("overrun", int'(overrun), int'(ovM));
      if (period_valid && (!prevValid || prevAck || overrun)) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_result: got period_out=%0d, expected no result (t=%0t)",
                     period_out, $time);
         end else begin
            result_t e;
            e = expQ.pop_front();
            checkOutput("period_out", int'(period_out), e.period);
            checkOutput("result_overrun", int'(overrun), int'(e.ov));
         end
         resultCount++;
         lastPeriod = int'(period_out);
         if (overrun) ovCount++;
      end
      prevValid = period_valid;
      prevAck   = period_ack;
   end

   initial begin
      int rc0;
      int ov0;
      reset_in   = 1'b1;
      sig_in     = 1'b0;
      period_ack = 1'b1;
      waitCycles(3);
      checkOutput("reset_stalled", int'(stalled), 1);
      checkOutput("reset_valid", int'(period_valid), 0);
      checkOutput("reset_period_out", int'(period_out), 0);
      reset_in = 1'b0;

      // Steady train, 40-cycle period, edges off the tick phase
      $display("[TB] steady train");
      goIdle();
      alignPhase(0);
      rc0 = resultCount;
      ov0 = ovCount;
      applyStimulus(6, 20, 20);
      checkOutput("steady_count", resultCount - rc0, 5);
      checkOutput("steady_period", lastPeriod, 10);
      checkOutput("steady_overruns", ovCount - ov0, 0);
      checkOutput("steady_stalled", int'(stalled), 0);

      // Edges phase-locked to ticks: coincident ticks are discarded
      $display("[TB] phase-locked train");
      goIdle();
      alignPhase(2);
      rc0 = resultCount;
      applyStimulus(4, 20, 20);
      checkOutput("locked_count", resultCount - rc0, 3);
      checkOutput("locked_period", lastPeriod, 9);

      // No ack: result held, third edge overwrites and flags overrun
      $display("[TB] no ack");
      goIdle();
      period_ack = 1'b0;
      alignPhase(0);
      ov0 = ovCount;
      applyStimulus(1, 20, 20);
      sig_in = 1'b1;
      waitCycles(20);
      checkOutput("noack_period", lastPeriod, 10);
      checkOutput("noack_valid", int'(period_valid), 1);
      applyStimulus(1, 0, 20);
      applyStimulus(1, 20, 20);
      checkOutput("noack_overruns", ovCount - ov0, 1);
      checkOutput("noack_valid_held", int'(period_valid), 1);
      period_ack = 1'b1;
      waitCycles(1);
      checkOutput("ack_clears_valid", int'(period_valid), 0);

      // Stall: arm, then hold the input high past the timeout
      $display("[TB] stall");
      goIdle();
      alignPhase(0);
      sig_in = 1'b1;
      waitCycles(500);
      checkOutput("stall_flag", int'(stalled), 1);
      sig_in = 1'b0;
      waitCycles(20);
      rc0 = resultCount;
      applyStimulus(2, 20, 20);
      checkOutput("stall_recover_count", resultCount - rc0, 1);
      checkOutput("stall_recover_period", lastPeriod, 10);

      // Boundary: 99 ticks reports, 100 ticks times out
      $display("[TB] boundary");
      goIdle();
      alignPhase(0);
      rc0 = resultCount;
      applyStimulus(1, 20, 376);
      applyStimulus(1, 20, 0);
      checkOutput("boundary_99", lastPeriod, 99);
      checkOutput("boundary_count", resultCount - rc0, 1);
      checkOutput("boundary_stalled", int'(stalled), 0);
      sig_in = 1'b0;
      waitCycles(380);
      applyStimulus(1, 20, 20);
      checkOutput("boundary_100_no_result", resultCount - rc0, 1);
      checkOutput("boundary_rearmed", int'(stalled), 0);

      // Random gaps and random acknowledgement
      $display("[TB] random");
      randomAck = 1'b1;
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1, int'($urandom_range(1, 150)), int'($urandom_range(1, 150)));
      end
      randomAck = 1'b0;
      period_ack = 1'b1;
      waitCycles(10);

      // Asynchronous reset in the middle of a measurement
      $display("[TB] reset mid-measurement");
      goIdle();
      period_ack = 1'b0;
      alignPhase(0);
      applyStimulus(1, 20, 20);
      applyStimulus(1, 20, 30);
      checkOutput("prereset_valid", int'(period_valid), 1);
      #1;
      reset_in = 1'b1;
      #1;
      checkOutput("async_reset_valid", int'(period_valid), 0);
      checkOutput("async_reset_period_out", int'(period_out), 0);
      checkOutput("async_reset_overrun", int'(overrun), 0);
      checkOutput("async_reset_stalled", int'(stalled), 1);
      waitCycles(3);
      #1;
      reset_in   = 1'b0;
      period_ack = 1'b1;
      alignPhase(0);
      rc0 = resultCount;
      applyStimulus(1, 20, 20);
      checkOutput("postreset_first_edge", resultCount - rc0, 0);
      checkOutput("postreset_armed", int'(stalled), 0);
      applyStimulus(1, 20, 20);
      checkOutput("postreset_second_edge", resultCount - rc0, 1);
      checkOutput("postreset_period", lastPeriod, 10);

      waitCycles(5);
      checkOutput("queue_drained", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Receive-side counterpart of the tick generator. Measures the interval between successive rising edges of an asynchronous input, such as a wheel encoder or sensor pulse train.
- The interval is counted in units of an externally supplied clock-enable tick.
- Feeds measured periods, with a valid/ack handshake, to the speed/PID datapath.
- Flags timeouts (input stalled) and overruns (result overwritten before it was acknowledged).

Parameters:
- CNT_WIDTH, 16, width of period counter and period_out.
- TIMEOUT, 50000, tick count at which a measurement is abandoned. Must satisfy 1 <= TIMEOUT <= 2^CNT_WIDTH-1.
- SYNC_STAGES, 2, synchronizer flops on sig_in. Must be >= 2.

Ports:
- clk_in  input  1  system clock.
- reset_in  input  1  asynchronous, active-high reset.
- tick_en  input  1  one-cycle clock-enable pulse; the counting time base.
- sig_in  input  1  asynchronous measured signal.
- period_ack  input  1  consumer acknowledges period_out.
- period_out  output  CNT_WIDTH  last completed period, in ticks.
- period_valid  output  1  period_out holds an unacknowledged result.
- overrun  output  1  one-cycle pulse when a new result overwrites an unacknowledged one.
- stalled  output  1  high while no valid edge has been seen for TIMEOUT ticks.

Behaviour:
- Reset (async, immediate): the following all go to 0:
  - synchronizer flops and edge-history flop;
  - counter;
  - period_out, period_valid, overrun;
  - state = IDLE.
- stalled resets to 1: no signal has been seen yet.
- Synchronizer: sig_in passes through SYNC_STAGES flops.
  - edge = sync_last & ~prev, where prev is sync_last delayed one cycle.
  - One edge per rising transition. Falling edges are ignored.
- States: IDLE, MEASURE.
- IDLE:
  - counter held at 0; ticks ignored.
  - On edge: state goes to MEASURE, counter = 0, stalled = 0. No result is produced; the first edge only arms the measurement.
- MEASURE, evaluated in priority order:
  1. edge: period_out <= counter; period_valid <= 1; counter <= 0; stay in MEASURE. A tick_en in the same cycle is discarded (counted in neither interval).
  2. else tick_en with counter == TIMEOUT-1: counter <= 0; state goes to IDLE; stalled <= 1. period_out and period_valid are unchanged.
  3. else tick_en: counter <= counter + 1.
- Edge and timeout in the same cycle: edge wins (rule 1); no timeout.
- Max reportable period is TIMEOUT-1. Counter never exceeds TIMEOUT-1 and never wraps.
- Handshake:
  - period_valid stays high until period_ack is sampled high. It clears the next cycle unless a new result is captured in that same cycle.
  - New result and period_ack in the same cycle: period_valid stays 1, period_out is updated, overrun stays 0 (the old value was consumed).
  - New result while period_valid=1 and period_ack=0: period_out is overwritten, period_valid stays 1, overrun pulses 1 for one cycle.
  - period_ack while period_valid=0: ignored.
- Latency:
  - period_valid rises on the (SYNC_STAGES+1)-th clk_in rising edge after the first edge that samples sig_in high.
  - tick_en is not synchronized; it must be a same-clock-domain pulse.
- sig_in held constant: no edges. The counter times out, and the block remains in IDLE with stalled=1 indefinitely.
- Reset asserted mid-measurement: the partial count is lost; the next edge only re-arms.

Test Plan:
All scenarios use CNT_WIDTH=16, TIMEOUT=100, SYNC_STAGES=2. tick_en pulses every 4th clk_in cycle. sig_in edges never coincide with a tick unless stated.
- Steady train, sig_in rising every 40 cycles (duty 50%), ack held high:
  - no output after the first edge;
  - each later edge gives period_out=10 with period_valid pulsing 1 cycle;
  - stalled 1 -> 0 at the first edge; overrun never asserts.
- Edge coincides with tick_en, edges every 40 cycles phase-locked to ticks -> period_out=9 (coincident tick discarded).
- No ack, three edges 40 cycles apart:
  - period_valid stays high;
  - period_out=10 after the 2nd edge;
  - overrun pulses exactly once, at the 3rd edge's result;
  - an ack then clears period_valid the next cycle.
- Stall: one edge, then sig_in held high for 500 cycles:
  - after 100 ticks, stalled=1 and state returns to IDLE;
  - period_valid unchanged.
  - Next edges 40 cycles apart: the first only re-arms, the second reports 10.
- Boundary: edge spacing exactly 99 ticks (396 cycles, non-coincident) -> period_out=99 (99 = 0x63), stalled stays 0. Spacing of 100 ticks -> timeout, no result.
- Reset pulse of 3 cycles, asserted asynchronously mid-measurement:
  - outputs 0 and stalled=1 immediately, without waiting for a clock edge;
  - post-reset, the first edge produces no result.
